// File: rtl/suma_pkg.sv
`default_nettype none
// ============================================================================
// Module : suma_pkg
// Brief  : Shared FSM state encoding and Mode constants for suma_serial_nb.
// Rev    : 1.0  initial release
// ============================================================================
package suma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : suma_pkg
`default_nettype wire

// File: rtl/sumador_1b.sv
`default_nettype none
// ============================================================================
// Module : sumador_1b
// Brief  : Single-bit full adder, the only arithmetic cell of the serial adder.
// Rev    : 1.0  initial release
// ============================================================================
module sumador_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : sumador_1b
`default_nettype wire

// File: rtl/suma_serial_nb.sv
`default_nettype none
// ============================================================================
// Module : suma_serial_nb
// Brief  : Bit-serial add/subtract, LSB first, one bit per clock through one
//          full adder; registered result with carry/borrow/overflow flag.
// Rev    : 1.0  initial release
// ============================================================================
module suma_serial_nb
    import suma_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Init,
    input  logic             Mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ROut,
    output logic             Error,
    output logic             Busy,
    output logic             Done
);

    localparam int             CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sh;
    logic [WIDTH-1:0]  r_rout;
    logic [CW-1:0]     r_cnt;
    logic              r_mode;
    logic              r_carry;
    logic              r_err;
    logic              r_busy;
    logic              r_done;

    logic              w_b;
    logic              w_s;
    logic              w_cout;
    logic              w_err;

    // Subtraction is A + ~B + 1: invert B on the fly, carry was preloaded with Mode.
    assign w_b = r_b[0] ^ (r_mode == MODE_SUB);

    sumador_1b u_fa (
        .a    (r_a[0]),
        .b    (w_b),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // Evaluated only on the MSB cycle, where r_carry is the carry into the MSB.
    generate
        if (SIGNED != 0) begin : g_err_signed
            assign w_err = r_carry ^ w_cout;
        end else begin : g_err_unsigned
            assign w_err = w_cout ^ (r_mode == MODE_SUB);
        end
    endgenerate

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sh    <= '0;
            r_rout  <= '0;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Init) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_mode  <= Mode;
                        r_carry <= Mode;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sh    <= {w_s, r_sh[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == c_LAST) begin
                        r_rout  <= {w_s, r_sh[WIDTH-1:1]};
                        r_err   <= w_err;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ROut  = r_rout;
    assign Error = r_err;
    assign Busy  = r_busy;
    assign Done  = r_done;

endmodule : suma_serial_nb
`default_nettype wire

// File: tb/tb_suma_serial_nb.sv
`default_nettype none
// ============================================================================
// Module : tb_suma_serial_nb
// Brief  : Self-checking bench for suma_serial_nb (8-bit unsigned, 8-bit signed
//          and 3-bit unsigned instances) against an arithmetic reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_suma_serial_nb;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Init8 = 1'b0;
    logic       Init3 = 1'b0;
    logic       Mode  = 1'b0;
    logic [7:0] A     = 8'd0;
    logic [7:0] B     = 8'd0;

    always #5 Clock = ~Clock;

    logic [7:0] r0, r1;
    logic [2:0] r2;
    logic       e0, e1, e2, b0, b1, b2, d0, d1, d2;

    suma_serial_nb #(.WIDTH(8), .SIGNED(0)) u_d0 (
        .Clock(Clock), .Reset(Reset), .Init(Init8), .Mode(Mode), .A(A), .B(B),
        .ROut(r0), .Error(e0), .Busy(b0), .Done(d0));
    suma_serial_nb #(.WIDTH(8), .SIGNED(1)) u_d1 (
        .Clock(Clock), .Reset(Reset), .Init(Init8), .Mode(Mode), .A(A), .B(B),
        .ROut(r1), .Error(e1), .Busy(b1), .Done(d1));
    suma_serial_nb #(.WIDTH(3), .SIGNED(0)) u_d2 (
        .Clock(Clock), .Reset(Reset), .Init(Init3), .Mode(Mode), .A(A[2:0]), .B(B[2:0]),
        .ROut(r2), .Error(e2), .Busy(b2), .Done(d2));

    logic [7:0] o_r [3];
    logic       o_e [3];
    logic       o_b [3];
    logic       o_d [3];
    assign o_r[0] = r0;  assign o_r[1] = r1;  assign o_r[2] = {5'd0, r2};
    assign o_e[0] = e0;  assign o_e[1] = e1;  assign o_e[2] = e2;
    assign o_b[0] = b0;  assign o_b[1] = b1;  assign o_b[2] = b2;
    assign o_d[0] = d0;  assign o_d[1] = d1;  assign o_d[2] = d2;

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mw(input int d);
        return (d == 2) ? 3 : 8;
    endfunction

    function automatic int ms(input int d);
        return (d == 1) ? 1 : 0;
    endfunction

    // Reference arithmetic: plain integer add/sub and range checks.
    function automatic void calc(input int w, input int s, input logic m,
                                 input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] r, output logic e);
        longint mask, half, ua, ub, res, sa, sb;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = {56'd0, a} & mask;
        ub   = {56'd0, b} & mask;
        res  = m ? ua - ub : ua + ub;
        r    = 8'(res & mask);
        if (s == 0) begin
            e = m ? (ua < ub) : (res > mask);
        end else begin
            sa  = (ua >= half) ? ua - 2 * half : ua;
            sb  = (ub >= half) ? ub - 2 * half : ub;
            res = m ? sa - sb : sa + sb;
            e   = (res < -half) || (res > half - 1);
        end
    endfunction

    // Model: accepted at edge k -> result/Done after edge k+W, idle after k+W+1.
    bit         m_act [3];
    int         m_acc [3];
    logic [7:0] m_r   [3];
    logic [7:0] m_pr  [3];
    logic       m_e   [3];
    logic       m_pe  [3];
    logic       m_b   [3];
    logic       m_d   [3];
    int         ecnt = 0;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int d = 0; d < 3; d++) begin
                m_act[d] = 1'b0; m_r[d] = 8'd0; m_e[d] = 1'b0;
                m_b[d]   = 1'b0; m_d[d] = 1'b0;
            end
        end else begin
            ecnt++;
            for (int d = 0; d < 3; d++) begin
                logic [7:0] tr;
                logic       te;
                if (m_act[d] && ecnt == m_acc[d] + mw(d) + 1) begin
                    m_d[d]   = 1'b0;
                    m_act[d] = 1'b0;
                end else if (m_act[d] && ecnt == m_acc[d] + mw(d)) begin
                    m_r[d] = m_pr[d];
                    m_e[d] = m_pe[d];
                    m_b[d] = 1'b0;
                    m_d[d] = 1'b1;
                end else if (!m_act[d] && ((d == 2) ? Init3 : Init8)) begin
                    m_act[d] = 1'b1;
                    m_acc[d] = ecnt;
                    m_b[d]   = 1'b1;
                    calc(mw(d), ms(d), Mode, A, B, tr, te);
                    m_pr[d]  = tr;
                    m_pe[d]  = te;
                end
            end
        end
    end

    always @(negedge Clock) begin
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d_rout", d),  64'(o_r[d]), 64'(m_r[d]));
            chk($sformatf("d%0d_error", d), 64'(o_e[d]), 64'(m_e[d]));
            chk($sformatf("d%0d_busy", d),  64'(o_b[d]), 64'(m_b[d]));
            chk($sformatf("d%0d_done", d),  64'(o_d[d]), 64'(m_d[d]));
        end
    end

    task automatic run_op(input int d, input logic m, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic e, output int lat);
        @(negedge Clock);
        Mode = m; A = a; B = b;
        if (d == 2) Init3 = 1'b1; else Init8 = 1'b1;
        @(negedge Clock);
        Init3 = 1'b0; Init8 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge Clock);
            if (o_d[d] === 1'b1) begin
                lat = i;
                break;
            end
        end
        r = o_r[d];
        e = o_e[d];
        if (lat < 0) chk($sformatf("d%0d_done_timeout", d), 64'd0, 64'd1);
    endtask

    logic [7:0] rr;
    logic       ee;
    int         lat;
    int         ndone;
    int         dn[$];

    initial begin
        #1 Reset = 1'b0;
        repeat (3) @(negedge Clock);
        chk("rst_rout", 64'(r0), 64'd0);
        chk("rst_err",  64'(e0), 64'd0);
        chk("rst_busy", 64'(b0), 64'd0);
        chk("rst_done", 64'(d0), 64'd0);
        Reset = 1'b1;
        repeat (2) @(negedge Clock);

        run_op(0, 1'b0, 8'd200, 8'd100, rr, ee, lat);
        chk("add200_100_rout", 64'(rr), 64'd44);
        chk("add200_100_err",  64'(ee), 64'd1);
        chk("lat8", 64'(lat), 64'd8);
        run_op(0, 1'b1, 8'd5, 8'd7, rr, ee, lat);
        chk("sub5_7_rout", 64'(rr), 64'd254);
        chk("sub5_7_err",  64'(ee), 64'd1);
        run_op(0, 1'b1, 8'd7, 8'd5, rr, ee, lat);
        chk("sub7_5_rout", 64'(rr), 64'd2);
        chk("sub7_5_err",  64'(ee), 64'd0);

        run_op(1, 1'b0, 8'd100, 8'd50, rr, ee, lat);
        chk("s_add100_50_rout", 64'(rr), 64'h96);
        chk("s_add100_50_err",  64'(ee), 64'd1);
        run_op(1, 1'b1, 8'h80, 8'd1, rr, ee, lat);
        chk("s_subm128_1_rout", 64'(rr), 64'd127);
        chk("s_subm128_1_err",  64'(ee), 64'd1);
        run_op(1, 1'b0, 8'd253, 8'd5, rr, ee, lat);
        chk("s_addm3_5_rout", 64'(rr), 64'd2);
        chk("s_addm3_5_err",  64'(ee), 64'd0);

        // Abort an operation three edges after it was accepted.
        @(negedge Clock);
        Mode = 1'b0; A = 8'd20; B = 8'd30; Init8 = 1'b1;
        @(negedge Clock);
        Init8 = 1'b0;
        repeat (2) @(negedge Clock);
        @(posedge Clock);
        #2 Reset = 1'b0;
        #1;
        chk("abort_busy", 64'(b0), 64'd0);
        chk("abort_done", 64'(d0), 64'd0);
        chk("abort_rout", 64'(r0), 64'd0);
        chk("abort_err",  64'(e0), 64'd0);
        @(negedge Clock);
        Reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge Clock);
            if (d0 === 1'b1) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        run_op(0, 1'b0, 8'd20, 8'd30, rr, ee, lat);
        chk("post_abort_rout", 64'(rr), 64'd50);
        chk("post_abort_err",  64'(ee), 64'd0);

        // Init held high; operands change while operations are in flight.
        @(negedge Clock);
        Mode = 1'b0; A = 8'd10; B = 8'd20; Init8 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge Clock);
            if (d0 === 1'b1) begin
                dn.push_back(c);
                if (dn.size() == 1) chk("hold_res1", 64'(r0), 64'd30);
                if (dn.size() == 2) chk("hold_res2", 64'(r0), 64'd100);
                if (dn.size() == 3) chk("hold_res3", 64'(r0), 64'd110);
            end
            if (c == 4)  begin A = 8'd99; B = 8'd1;  end
            if (c == 15) begin A = 8'd50; B = 8'd60; end
        end
        Init8 = 1'b0;
        chk("hold_ndone", 64'(dn.size()), 64'd4);
        if (dn.size() > 0) chk("hold_first_done", 64'(dn[0]), 64'd8);
        for (int i = 1; i < dn.size(); i++)
            chk("hold_spacing", 64'(dn[i] - dn[i-1]), 64'd10);
        repeat (12) @(negedge Clock);

        run_op(2, 1'b0, 8'd3, 8'd4, rr, ee, lat);
        chk("w3_add3_4_rout", 64'(rr), 64'd7);
        chk("w3_add3_4_err",  64'(ee), 64'd0);
        chk("lat3", 64'(lat), 64'd3);
        run_op(2, 1'b0, 8'd7, 8'd1, rr, ee, lat);
        chk("w3_add7_1_rout", 64'(rr), 64'd0);
        chk("w3_add7_1_err",  64'(ee), 64'd1);
        run_op(2, 1'b1, 8'd2, 8'd5, rr, ee, lat);
        chk("w3_sub2_5_rout", 64'(rr), 64'd5);
        chk("w3_sub2_5_err",  64'(ee), 64'd1);

        repeat (3) @(negedge Clock);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", nerr);
        $fatal(1);
    end

endmodule : tb_suma_serial_nb
`default_nettype wire

// File: doc/suma_serial_nb.md
SUMA_SERIAL_NB -- requirements
Module: suma_serial_nb

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Parameter SIGNED, default 0, selects the Error rule: 0 = unsigned carry/borrow, 1 = two's-complement overflow.
REQ-003 Clock  in  1  single clock, all state updates on rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 Init  in  1  start request, sampled on the rising edge of Clock.
REQ-006 Mode  in  1  operation select: 0 = A+B, 1 = A-B.
REQ-007 A  in  WIDTH  first operand.
REQ-008 B  in  WIDTH  second operand.
REQ-009 ROut  out  WIDTH  registered result, low WIDTH bits.
REQ-010 Error  out  1  registered carry/borrow/overflow flag for ROut.
REQ-011 Busy  out  1  high while an operation is in progress.
REQ-012 Done  out  1  one-cycle pulse marking ROut/Error valid.

Function
REQ-013 Bit-serial datapath; one bit per clock, LSB first, through a single 1-bit full adder.
REQ-014 FSM states IDLE, RUN, DONE; Busy = 1 in RUN only, Done = 1 in DONE only.
REQ-015 IDLE with Init = 1 at an edge: capture A, B and Mode into internal registers; load carry with Mode; clear bit counter; go to RUN.
REQ-016 Subtraction uses the inverted captured B with carry-in 1; addition uses B with carry-in 0.
REQ-017 RUN: each edge adds bit 0 of the operand registers plus carry, shifts the sum bit into the MSB of an internal result shift register, shifts the operands right, updates carry, and increments the counter.
REQ-018 RUN to DONE on the edge that processes bit WIDTH-1; on that same edge ROut and Error load from the shift register and final carry.
REQ-019 Latency: an Init accepted at edge k gives Done high from edge k+WIDTH to edge k+WIDTH+1.
REQ-020 DONE returns to IDLE unconditionally after one cycle; Init is ignored in DONE and in RUN.
REQ-021 Throughput: one operation per WIDTH+2 cycles when Init is held high.
REQ-022 Error rule, SIGNED = 0: add gives carry-out of the MSB; sub gives the inverted carry-out (borrow, A < B).
REQ-023 Error rule, SIGNED = 1: carry-in of the MSB XOR carry-out of the MSB.
REQ-024 ROut and Error hold their value from DONE until the next DONE; they do not change during RUN.
REQ-025 Changes on A, B or Mode after capture do not affect the operation in flight.
REQ-026 The counter width is clog2(WIDTH)+1; no wrap-around occurs within a legal WIDTH.

Reset
REQ-027 Reset = 0 immediately forces state to IDLE and clears ROut, Error, Busy, Done, the counter, carry and all operand/shift registers, regardless of Clock.
REQ-028 Reset asserted mid-RUN aborts the operation, and no Done pulse is produced for it.
REQ-029 After Reset deasserts, the first Init sampled high starts a new operation normally.

Structure
REQ-030 Shared package suma_pkg holds the FSM state encoding (IDLE, RUN, DONE) and the Mode constants (MODE_ADD = 0, MODE_SUB = 1).
REQ-031 The 1-bit full adder is a separate sub-module named sumador_1b (ports a, b, cin, s, cout); the top module instantiates it exactly once.
REQ-032 No combinational path exists from any input to any output.

Verification
REQ-033 WIDTH=8, SIGNED=0, Mode=0, A=200, B=100 -> Done 8 cycles after accept, ROut=44, Error=1.
REQ-034 WIDTH=8, SIGNED=0, Mode=1, A=5, B=7 -> ROut=254, Error=1; then A=7, B=5 -> ROut=2, Error=0.
REQ-035 WIDTH=8, SIGNED=1: 100+50 -> ROut=0x96, Error=1; -128-1 -> ROut=127, Error=1; -3+5 -> ROut=2, Error=0.
REQ-036 WIDTH=8: Reset pulsed low 3 cycles after accept -> Busy, Done, ROut and Error read 0 immediately; no Done pulse follows; the next Init completes correctly.
REQ-037 Init held high, A/B changed during RUN -> results match the captured operands; Done pulses every 10 cycles.
REQ-038 WIDTH=3, SIGNED=0: 3+4 -> ROut=7, Error=0; 7+1 -> ROut=0, Error=1; Done 3 cycles after accept.
